// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Pure declarations: no logic, no latency.
// No backpressure of its own; imported by the arbiter, picker and bench.
package dmem_arb_pkg;

  localparam int NUM_SLOTS  = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef logic [$clog2(NUM_SLOTS)-1:0] slot_idx_t;

  // One slot's access request at the default widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two slot request/return ports plus the data_memory port.
// Wiring only, zero latency.
// Losing slot is held off by a low GNT; it keeps REQ and fields stable.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              P0_REQ;
  logic              P0_WE;
  logic [ADDR_W-1:0] P0_ADDR;
  logic [DATA_W-1:0] P0_WDATA;
  logic              P0_GNT;
  logic              P0_RVALID;
  logic [DATA_W-1:0] P0_RDATA;

  logic              P1_REQ;
  logic              P1_WE;
  logic [ADDR_W-1:0] P1_ADDR;
  logic [DATA_W-1:0] P1_WDATA;
  logic              P1_GNT;
  logic              P1_RVALID;
  logic [DATA_W-1:0] P1_RDATA;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_RDATA;

  logic [CNT_W-1:0]  CONFLICT_CNT;

  // Slots and memory side: drives requests and read data, sees grants.
  modport master (
    output P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
    output P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
    output MEM_RDATA,
    input  P0_GNT, P0_RVALID, P0_RDATA,
    input  P1_GNT, P1_RVALID, P1_RDATA,
    input  MEM_ADDR, MEM_WDATA, MEM_WE, CONFLICT_CNT
  );

  // Arbiter side.
  modport slave (
    input  P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
    input  P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
    input  MEM_RDATA,
    output P0_GNT, P0_RVALID, P0_RDATA,
    output P1_GNT, P1_RVALID, P1_RDATA,
    output MEM_ADDR, MEM_WDATA, MEM_WE, CONFLICT_CNT
  );

endinterface

// File: rtl/dmem_port_arbiter_picker.sv
// Two-slot one-hot grant picker; macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
// Purely combinational, zero latency.
// Loser simply sees its grant bit low; in fixed priority slot 1 may starve.
module dmem_arb_picker
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  slot_idx_t            pref,
`endif
  input  logic [NUM_SLOTS-1:0] req,
  output logic [NUM_SLOTS-1:0] gnt
);

  // A lone requester wins outright; contention resolved by policy.
  always_comb begin
    gnt = req;
    if (&req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      gnt = (pref == slot_idx_t'(1)) ? 2'b10 : 2'b01;
`else
      gnt = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data_memory between two load/store slots; DMEM_ARB_ROUND_ROBIN_EN enables round-robin.
// Grant is combinational (0 cycles); load data returns registered 1 cycle after the grant.
// One access per cycle; the losing slot holds REQ and fields until granted.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                CLK,
  input logic                RESET_N,
  dmem_port_arbiter_if.slave bus
);

  logic [NUM_SLOTS-1:0] req;
  logic [NUM_SLOTS-1:0] gnt;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_we;
  logic [NUM_SLOTS-1:0] rvalid;
  logic [DATA_W-1:0]    rdata0;
  logic [DATA_W-1:0]    rdata1;
  logic [CNT_W-1:0]     cnt;

  assign req = {bus.P1_REQ, bus.P0_REQ};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  slot_idx_t pref;

  dmem_arb_picker u_picker (
    .pref (pref),
    .req  (req),
    .gnt  (gnt)
  );

  // Hand preference to the other slot after every grant; idle cycles keep it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pref <= '0;
    end else if (gnt[0]) begin
      pref <= slot_idx_t'(1);
    end else if (gnt[1]) begin
      pref <= slot_idx_t'(0);
    end
  end
`else
  dmem_arb_picker u_picker (
    .req (req),
    .gnt (gnt)
  );
`endif

  // Steer the winner's fields onto the memory port; idle drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (gnt[0]) begin
      mem_addr  = bus.P0_ADDR;
      mem_wdata = bus.P0_WDATA;
      mem_we    = bus.P0_WE;
    end else if (gnt[1]) begin
      mem_addr  = bus.P1_ADDR;
      mem_wdata = bus.P1_WDATA;
      mem_we    = bus.P1_WE;
    end
  end

  // Capture load data for the granted slot; RDATA holds when no load returns.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rvalid <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rvalid[0] <= gnt[0] & ~bus.P0_WE;
      rvalid[1] <= gnt[1] & ~bus.P1_WE;
      if (gnt[0] && !bus.P0_WE) rdata0 <= bus.MEM_RDATA;
      if (gnt[1] && !bus.P1_WE) rdata1 <= bus.MEM_RDATA;
    end
  end

  // Count contended cycles, sticking at all-ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (&req && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.P0_GNT       = gnt[0];
  assign bus.P1_GNT       = gnt[1];
  assign bus.P0_RVALID    = rvalid[0];
  assign bus.P1_RVALID    = rvalid[1];
  assign bus.P0_RDATA     = rdata0;
  assign bus.P1_RDATA     = rdata1;
  assign bus.MEM_ADDR     = mem_addr;
  assign bus.MEM_WDATA    = mem_wdata;
  // No store may commit while reset is held, whatever the slots request.
  assign bus.MEM_WE       = mem_we & RESET_N;
  assign bus.CONFLICT_CNT = cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
// Model predicts grants, memory contents, load returns and the contention count per cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic CLK;
  logic RESET_N;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The data_memory itself: combinational read, write on the rising edge.
  logic [DW-1:0] mem [256];
  assign bus.MEM_RDATA = mem[bus.MEM_ADDR];
  always @(posedge CLK) if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  int            m_pref;
  int            m_cnt;
  logic          m_rv [2];
  logic [DW-1:0] m_rd [2];
  logic          m_req [2];
  dmem_req_t     m_q [2];
  logic          s_g [2];
  logic          s_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input dmem_req_t q);
    m_req[s] = r;
    m_q[s]   = q;
    if (s == 0) begin
      bus.P0_REQ = r; bus.P0_WE = q.we; bus.P0_ADDR = q.addr; bus.P0_WDATA = q.wdata;
    end else begin
      bus.P1_REQ = r; bus.P1_WE = q.we; bus.P1_ADDR = q.addr; bus.P1_WDATA = q.wdata;
    end
  endtask

  function automatic dmem_req_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
    dmem_req_t q;
    q.we = we; q.addr = a; q.wdata = d;
    return q;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return 1 unit after the rising edge.
  task automatic cycle();
    int w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe;
    @(negedge CLK);
    if (!RESET_N) begin
      m_pref = 0; m_cnt = 0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end
    // Winner: lone requester, else policy.
    w = -1;
    if (m_req[0] && m_req[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w = m_pref;
`else
      w = 0;
`endif
    end else if (m_req[0]) w = 0;
    else if (m_req[1]) w = 1;
    ea = (w >= 0) ? m_q[w].addr : '0;
    ed = (w >= 0) ? m_q[w].wdata : '0;
    ewe = (w >= 0) ? m_q[w].we : 1'b0;
    s_g[0] = bus.P0_GNT;
    s_g[1] = bus.P1_GNT;
    s_we   = bus.MEM_WE;
    if (RESET_N) begin
      chk("p0_gnt", 32'(bus.P0_GNT), 32'(w == 0));
      chk("p1_gnt", 32'(bus.P1_GNT), 32'(w == 1));
      chk("mem_addr", 32'(bus.MEM_ADDR), 32'(ea));
      chk("mem_wdata", 32'(bus.MEM_WDATA), 32'(ed));
      chk("mem_we", 32'(bus.MEM_WE), 32'(ewe));
    end else begin
      chk("mem_we_rst", 32'(bus.MEM_WE), 32'd0);
    end
    chk("p0_rvalid", 32'(bus.P0_RVALID), 32'(m_rv[0]));
    chk("p1_rvalid", 32'(bus.P1_RVALID), 32'(m_rv[1]));
    chk("p0_rdata", 32'(bus.P0_RDATA), 32'(m_rd[0]));
    chk("p1_rdata", 32'(bus.P1_RDATA), 32'(m_rd[1]));
    chk("conflict_cnt", 32'(bus.CONFLICT_CNT), 32'(m_cnt));
    if (RESET_N) begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (w >= 0) begin
        if (m_q[w].we) ref_mem[m_q[w].addr] = m_q[w].wdata;
        else begin
          m_rv[w] = 1;
          m_rd[w] = ref_mem[m_q[w].addr];
        end
        m_pref = 1 - w;
      end
      if (m_req[0] && m_req[1] && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    cycle();
    RESET_N = 1'b1;
  endtask

  logic pend [2];
  dmem_req_t q0, q1;
  int g0_cnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_pref = 0; m_cnt = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;

    // Reset with slot 0 trying to store: memory must not be written.
    RESET_N = 1'b0;
    drive(0, 1'b1, mk(1'b1, 8'h33, 8'hEE));
    drive(1, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("rst_mem_we", 32'(s_we), 32'd0);
    cycle();
    chk("rst_no_commit", 32'(mem[8'h33]), 32'h00);
    chk("rst_cnt", 32'(bus.CONFLICT_CNT), 32'd0);
    chk("rst_rvalid0", 32'(bus.P0_RVALID), 32'd0);
    RESET_N = 1'b1;

    // Single store then load on slot 0.
    drive(0, 1'b1, mk(1'b1, 8'h00, 8'hFF));
    cycle();
    chk("st_gnt", 32'(s_g[0]), 32'd1);
    chk("st_no_rvalid", 32'(bus.P0_RVALID), 32'd0);
    drive(0, 1'b1, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("ld_gnt", 32'(s_g[0]), 32'd1);
    chk("ld_rvalid", 32'(bus.P0_RVALID), 32'd1);
    chk("ld_rdata", 32'(bus.P0_RDATA), 32'hFF);
    drive(0, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("ld_pulse_end", 32'(bus.P0_RVALID), 32'd0);
    chk("ld_rdata_hold", 32'(bus.P0_RDATA), 32'hFF);

    // Contention right after reset: slot 0 first, slot 1 the next cycle.
    do_reset();
    drive(0, 1'b1, mk(1'b0, 8'h00, 8'h00));
    drive(1, 1'b1, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("cont_g0", 32'(s_g[0]), 32'd1);
    chk("cont_g1", 32'(s_g[1]), 32'd0);
    chk("cont_rv0", 32'(bus.P0_RVALID), 32'd1);
    drive(0, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("cont_g1_next", 32'(s_g[1]), 32'd1);
    chk("cont_rv1", 32'(bus.P1_RVALID), 32'd1);
    chk("cont_rd1", 32'(bus.P1_RDATA), 32'hFF);
    chk("cont_cnt", 32'(bus.CONFLICT_CNT), 32'd1);
    drive(1, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();

    // Sustained contention for 6 cycles.
    do_reset();
    drive(0, 1'b1, mk(1'b0, 8'h01, 8'h00));
    drive(1, 1'b1, mk(1'b0, 8'h02, 8'h00));
    g0_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      chk("sus_g0", 32'(s_g[0]), 32'((i % 2) == 0));
`else
      chk("sus_g0", 32'(s_g[0]), 32'd1);
`endif
      if (s_g[0]) g0_cnt++;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    chk("sus_g0_total", 32'(g0_cnt), 32'd3);
`else
    chk("sus_g0_total", 32'(g0_cnt), 32'd6);
`endif
    chk("sus_cnt", 32'(bus.CONFLICT_CNT), 32'd6);
    drive(0, 1'b0, mk(1'b0, 8'h00, 8'h00));
    drive(1, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();

    // Cross-slot ordering: slot 1 stores, slot 0 loads the same address.
    drive(1, 1'b1, mk(1'b1, 8'h10, 8'h5A));
    cycle();
    chk("x_st_g1", 32'(s_g[1]), 32'd1);
    drive(1, 1'b0, mk(1'b0, 8'h00, 8'h00));
    drive(0, 1'b1, mk(1'b0, 8'h10, 8'h00));
    cycle();
    chk("x_ld_rv0", 32'(bus.P0_RVALID), 32'd1);
    chk("x_ld_rd0", 32'(bus.P0_RDATA), 32'h5A);
    drive(0, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();

    // Counter saturation.
    do_reset();
    drive(0, 1'b1, mk(1'b0, 8'h03, 8'h00));
    drive(1, 1'b1, mk(1'b0, 8'h04, 8'h00));
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_cnt", 32'(bus.CONFLICT_CNT), 32'hFF);
    drive(1, 1'b0, mk(1'b0, 8'h00, 8'h00));

    // Reset while a load is in flight, then a store held through reset.
    drive(0, 1'b1, mk(1'b0, 8'h00, 8'h00));
    cycle();
    chk("mid_rv_before", 32'(bus.P0_RVALID), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rv_dropped", 32'(bus.P0_RVALID), 32'd0);
    chk("mid_rdata_clr", 32'(bus.P0_RDATA), 32'd0);
    chk("mid_cnt_clr", 32'(bus.CONFLICT_CNT), 32'd0);
    drive(0, 1'b1, mk(1'b1, 8'h20, 8'hA5));
    cycle();
    chk("mid_no_commit", 32'(mem[8'h20]), 32'h00);
    chk("mid_rv_held", 32'(bus.P0_RVALID), 32'd0);
    RESET_N = 1'b1;
    drive(0, 1'b0, mk(1'b0, 8'h00, 8'h00));
    cycle();

    // Random traffic: requests held until granted, occasionally withdrawn.
    pend[0] = 1'b0; pend[1] = 1'b0;
    s_g[0] = 1'b0; s_g[1] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (pend[s] && !s_g[s]) begin
          if ($urandom_range(0, 9) == 0) pend[s] = 1'b0;
        end else begin
          pend[s] = ($urandom_range(0, 9) < 7);
          m_q[s] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
        end
        drive(s, pend[s], m_q[s]);
      end
      cycle();
    end
    chk("final_mem_match", 32'(mem[8'h05]), 32'(ref_mem[8'h05]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
